// File: rtl/mem_responder.sv
// Word-addressed memory slave with a fixed request-to-response latency.
// Single outstanding request, byte-lane writes, and errors for out-of-range or ambiguous ops.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_BAD} op_t;

  state_t      state;
  op_t         op;
  logic [29:0] idx;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [3:0]  cnt;
  logic        gap;

  logic [31:0] mem [DEPTH];

  op_t         in_op, cur_op;
  logic [29:0] cur_idx;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_be;
  logic        accept, held, hit, go_resp;

  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_address[1:0];

  // With LATENCY=1 the response is produced at the acceptance edge, so the
  // live inputs stand in for the latched copies while in IDLE.
  always_comb begin
    in_op  = (mem_read && mem_write) ? OP_BAD : (mem_read ? OP_RD : OP_WR);
    accept = (state == IDLE) && !gap && (mem_read || mem_write);
    case (op)
      OP_RD:   held = mem_read;
      OP_WR:   held = mem_write;
      default: held = mem_read || mem_write;
    endcase
    if (state == IDLE) begin
      cur_op    = in_op;
      cur_idx   = mem_address[31:2];
      cur_wdata = mem_wdata;
      cur_be    = mem_byte_enable;
    end else begin
      cur_op    = op;
      cur_idx   = idx;
      cur_wdata = wdata;
      cur_be    = be;
    end
    hit     = cur_idx < 30'(DEPTH);
    go_resp = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd0) && held);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op        <= OP_RD;
      idx       <= '0;
      wdata     <= '0;
      be        <= '0;
      cnt       <= '0;
      gap       <= 1'b0;
      mem_resp  <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_resp <= go_resp;
      mem_err  <= go_resp && ((cur_op == OP_BAD) || !hit);
      if (go_resp && cur_op == OP_RD)
        mem_rdata <= hit ? mem[cur_idx[AW-1:0]] : '0;
      gap <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op    <= in_op;
          idx   <= mem_address[31:2];
          wdata <= mem_wdata;
          be    <= mem_byte_enable;
          if (LATENCY == 1) state <= RESP;
          else begin
            cnt   <= 4'(LATENCY - 2);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!held)            state <= IDLE;
          else if (cnt == 4'd0) state <= RESP;
          else                  cnt   <= cnt - 4'd1;
        end
        RESP: begin
          // blocks re-acceptance of a request still held from this response
          state <= IDLE;
          gap   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && go_resp && cur_op == OP_WR && hit)
      for (int b = 0; b < 4; b++)
        if (cur_be[b]) mem[cur_idx[AW-1:0]][8*b +: 8] <= cur_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_mem_responder.sv
// Three responders (LATENCY 2, 4, 3) each tracked by a transaction-level model
// keyed on cycle numbers, plus directed transactions with literal expectations.
module tb_mem_responder;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd [N];
  logic        wr [N];
  logic [31:0] ad [N];
  logic [31:0] wd [N];
  logic [3:0]  be [N];
  logic [31:0] rdata [N];
  logic        resp [N];
  logic        err [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 4 : 3);

    mem_responder #(.DEPTH(256), .LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .mem_read(rd[g]), .mem_write(wr[g]),
      .mem_address(ad[g]), .mem_wdata(wd[g]), .mem_byte_enable(be[g]),
      .mem_rdata(rdata[g]), .mem_resp(resp[g]), .mem_err(err[g])
    );

    // Model: cycle c is the cycle ending at the edge where cyc becomes c.
    logic [31:0] mm [int];
    int          cyc = 0, free_at = 0, acc = 0, k = 0;
    bit          pend = 0, lr = 0, lw = 0, bad = 0, hold = 0;
    logic [29:0] li = '0;
    logic [31:0] lwd = '0, w = '0;
    logic [3:0]  lbe = '0;
    bit          e_resp = 0, e_err = 0, rk = 1;
    logic [31:0] e_rdata = '0;

    initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pend = 0; e_resp = 0; e_err = 0; e_rdata = '0; rk = 1; free_at = cyc + 1;
      end else begin
        e_resp = 0; e_err = 0;
        hold = (lr && lw) ? (rd[g] || wr[g]) : (lr ? rd[g] : wr[g]);
        if (!pend && cyc >= free_at && (rd[g] || wr[g])) begin
          pend = 1; acc = cyc; lr = rd[g]; lw = wr[g];
          li = ad[g][31:2]; lwd = wd[g]; lbe = be[g];
        end else if (pend && !hold) begin
          pend = 0; free_at = cyc + 1;
        end
        if (pend && cyc == acc + L - 1) begin
          pend = 0; free_at = cyc + 3;  // response cycle, one blocked cycle, then free
          e_resp = 1;
          bad = (lr && lw) || (li >= 30'd256);
          e_err = bad;
          k = int'(li);
          if (lr && !lw) begin
            if (bad) begin e_rdata = '0; rk = 1; end
            else if (mm.exists(k)) begin e_rdata = mm[k]; rk = 1; end
            else rk = 0;
          end else if (lw && !lr && !bad) begin
            if (mm.exists(k)) begin
              w = mm[k];
              for (int b = 0; b < 4; b++) if (lbe[b]) w[8*b +: 8] = lwd[8*b +: 8];
              mm[k] = w;
            end else if (lbe == 4'hF) mm[k] = lwd;
          end
        end
      end
    end

    initial begin
      @(posedge clk);
      forever begin
        @(negedge clk);
        chk($sformatf("model_resp%0d", g), 32'(resp[g]), 32'(e_resp));
        if (e_resp) chk($sformatf("model_err%0d", g), 32'(err[g]), 32'(e_err));
        if (rk) chk($sformatf("model_rdata%0d", g), rdata[g], e_rdata);
      end
    end
  end

  // Drive one request and hold it until mem_resp; returns after the blocked cycle.
  task automatic xact(input int i, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m,
                      output int lat, output logic [31:0] rv, output logic ev);
    rd[i] = r; wr[i] = w; ad[i] = a; wd[i] = d; be[i] = m;
    lat = -1; rv = '0; ev = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (resp[i]) begin lat = n; rv = rdata[i]; ev = err[i]; break; end
    end
    rd[i] = 1'b0; wr[i] = 1'b0;
    if (lat < 0) begin
      errors++; checks++;
      $display("FAIL xact_timeout: inst %0d addr %h got no response expected one", i, a);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded expected completion");
    $fatal(1);
  end

  initial begin
    int lat, cnt, first, second;
    logic [31:0] rv;
    logic ev;
    for (int i = 0; i < N; i++) begin
      rd[i] = 0; wr[i] = 0; ad[i] = '0; wd[i] = '0; be[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_resp%0d", i), 32'(resp[i]), 32'd0);
      chk($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
      chk($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
    end
    rst = 1'b0;

    // LATENCY=2: write-then-read
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rv, ev);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_err", 32'(ev), 32'd0);
    xact(0, 1, 0, 32'h10, 32'h0, 4'h0, lat, rv, ev);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_data", rv, 32'hDEADBEEF);
    chk("rd_err", 32'(ev), 32'd0);

    // byte masking
    xact(0, 0, 1, 32'h20, 32'h11223344, 4'hF, lat, rv, ev);
    xact(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rv, ev);
    xact(0, 1, 0, 32'h20, 32'h0, 4'h0, lat, rv, ev);
    chk("mask_data", rv, 32'h11BB33DD);

    // empty mask completes without changing memory
    xact(0, 0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, lat, rv, ev);
    chk("be0_err", 32'(ev), 32'd0);
    xact(0, 1, 0, 32'h10, 32'h0, 4'h0, lat, rv, ev);
    chk("be0_data", rv, 32'hDEADBEEF);

    // errors
    xact(0, 1, 0, 32'h400, 32'h0, 4'h0, lat, rv, ev);
    chk("oob_rd_err", 32'(ev), 32'd1);
    chk("oob_rd_data", rv, 32'h0);
    xact(0, 0, 1, 32'h400, 32'h55555555, 4'hF, lat, rv, ev);
    chk("oob_wr_err", 32'(ev), 32'd1);
    xact(0, 1, 1, 32'h10, 32'h0, 4'hF, lat, rv, ev);
    chk("both_err", 32'(ev), 32'd1);
    chk("both_latency", 32'(lat), 32'd2);
    xact(0, 1, 0, 32'h10, 32'h0, 4'h0, lat, rv, ev);
    chk("both_nochange", rv, 32'hDEADBEEF);

    // read held across responses: one pulse per request, period LATENCY+2
    rd[0] = 1'b1; ad[0] = 32'h10; cnt = 0; first = -1; second = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (resp[0]) begin
        cnt++;
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
    end
    rd[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_count", 32'(cnt), 32'd3);
    chk("b2b_first", 32'(first), 32'd2);
    chk("b2b_period", 32'(second - first), 32'd4);

    // LATENCY=4: abort by dropping the read one cycle after acceptance
    xact(1, 0, 1, 32'h10, 32'h0BADF00D, 4'hF, lat, rv, ev);
    chk("l4_wr_latency", 32'(lat), 32'd4);
    rd[1] = 1'b1; ad[1] = 32'h10;
    @(negedge clk);
    rd[1] = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp[1]) cnt++;
    end
    chk("abort_noresp", 32'(cnt), 32'd0);
    xact(1, 1, 0, 32'h10, 32'h0, 4'h0, lat, rv, ev);
    chk("l4_rd_latency", 32'(lat), 32'd4);
    chk("l4_rd_data", rv, 32'h0BADF00D);

    // LATENCY=3: reset while a write waits
    xact(2, 0, 1, 32'h40, 32'h12345678, 4'hF, lat, rv, ev);
    xact(2, 1, 0, 32'h40, 32'h0, 4'h0, lat, rv, ev);
    chk("l3_pre_data", rv, 32'h12345678);
    wr[2] = 1'b1; ad[2] = 32'h40; wd[2] = 32'hCAFEF00D; be[2] = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b1; wr[2] = 1'b0;
    @(negedge clk);
    chk("rstmid_resp", 32'(resp[2]), 32'd0);
    chk("rstmid_err", 32'(err[2]), 32'd0);
    chk("rstmid_rdata", rdata[2], 32'h0);
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp[2]) cnt++;
    end
    chk("rstmid_noresp", 32'(cnt), 32'd0);
    xact(2, 1, 0, 32'h40, 32'h0, 4'h0, lat, rv, ev);
    chk("rstmid_mem", rv, 32'h12345678);
    chk("l3_rd_latency", 32'(lat), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
